rom_ctrl_chk_seq: RTL and testbench
===================================

ROM_CTRL_CHK_SEQ -- requirements
Module: rom_ctrl_chk_seq

Interface
REQ-001 SHALL have parameter RomDepth, default 16, number of ROM words (min 9).
REQ-002 SHALL have parameter NumTopWords, default 8, number of trailing digest words.
REQ-003 SHALL have parameter DW, default 39, ROM word width; AW = $clog2(RomDepth), derived.
REQ-004 SHALL have port clk_i  in  1  clock; single clock domain.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_i  in  1  begin the ROM sweep.
REQ-007 SHALL have port chk_req_o  out  1  read request to the ROM mux checker side.
REQ-008 SHALL have port chk_addr_o  out  AW  word address of the request.
REQ-009 SHALL have port chk_rdata_i  in  DW  scrambled read data.
REQ-010 SHALL have port rom_rvalid_i  in  1  read response, one cycle after the request.
REQ-011 SHALL have port data_o  out  DW  buffered word to the hash/compare consumer.
REQ-012 SHALL have port data_vld_o  out  1  data_o valid.
REQ-013 SHALL have port data_rdy_i  in  1  consumer accepts data_o.
REQ-014 SHALL have port top_o  out  1  data_o belongs to the last NumTopWords words.
REQ-015 SHALL have port sel_bus_o  out  4  mubi4_t; MuBi4True hands the ROM to the bus.
REQ-016 SHALL have port alert_o  out  1  fatal consistency alert, registered.

Function
REQ-017 SHALL implement FSM states Idle, Read, Wait, Done; encoding sparse (Hamming distance >=3).
REQ-018 Idle: chk_req_o=0; start_i=1 -> Read with address counter 0.
REQ-019 Read: chk_req_o=1 for exactly one cycle, chk_addr_o = counter; next state Wait.
REQ-020 Wait: rom_rvalid_i=1 writes chk_rdata_i into a one-entry buffer and increments counter; ROM latency is exactly one cycle.
REQ-021 Wait -> Read when the buffer is empty or drains (data_vld_o & data_rdy_i) in that cycle and counter < RomDepth; -> Done when counter == RomDepth and buffer drained.
REQ-022 A request SHALL never be issued while the buffer is full and not draining; at most one request outstanding.
REQ-023 data_vld_o SHALL assert the cycle after capture and hold, with data_o/top_o stable, until data_rdy_i=1.
REQ-024 top_o SHALL be 1 iff buffered word address >= RomDepth-NumTopWords.
REQ-025 Done: sel_bus_o = MuBi4True; all other states sel_bus_o = MuBi4False; Done is terminal until reset.
REQ-026 start_i outside Idle SHALL be ignored.
REQ-027 Counter width AW+1; no wrap: counter saturates at RomDepth.
REQ-028 alert_o SHALL set (sticky until reset) on: rom_rvalid_i in any state other than Wait; no rom_rvalid_i in Wait the cycle after Read; invalid FSM encoding; mismatch between the address counter and a redundant down-counter (RomDepth minus words read).
REQ-029 On invalid FSM encoding the FSM SHALL go to a terminal Invalid state with sel_bus_o = MuBi4False and chk_req_o=0.

Reset
REQ-030 Reset values: state Idle, counters 0/RomDepth, buffer empty, chk_req_o=0, chk_addr_o=0, data_vld_o=0, data_o=0, top_o=0, sel_bus_o=MuBi4False, alert_o=0.
REQ-031 Reset asserted mid-sweep SHALL abandon the sweep immediately; an rvalid arriving in the first cycle after reset release SHALL raise alert_o.

Structure
REQ-032 State encoding typedef and MuBi4 constants SHALL live in rom_ctrl_pkg / prim_mubi_pkg.
REQ-033 The buffer plus top-flag SHALL be one sub-module, rom_ctrl_chk_buf.
REQ-034 The sel_bus_o register SHALL use prim_flop with reset value MuBi4False.

Verification
REQ-035 RomDepth=16, data_rdy_i=1, start_i pulse -> 16 requests, addresses 0..15, 16 words out, top_o=1 on words 8..15, sel_bus_o=MuBi4True after last handshake.
REQ-036 data_rdy_i=0 for 10 cycles after first word -> data_o held, chk_req_o=0 throughout, sweep resumes on rdy with address 1.
REQ-037 rom_rvalid_i=1 injected in Idle -> alert_o=1 next cycle, stays 1.
REQ-038 Force redundant down-counter to wrong value at word 5 -> alert_o=1 next cycle.
REQ-039 rst_ni low at word 7 -> all outputs to reset values same cycle; new start_i restarts at address 0.
REQ-040 start_i pulsed during Wait at word 3 -> no effect, address sequence unchanged.

Source files
------------

// File: rtl/prim_mubi_pkg.sv
// Multi-bit boolean encoding shared by blocks that hand over resources.
// A 4-bit mubi value is only "true" or "false" for the two exact patterns
// below. Every other pattern is invalid, so a single bit flip cannot turn
// a false into a true.
package prim_mubi_pkg;

  typedef logic [3:0] mubi4_t;

  parameter mubi4_t MuBi4True  = 4'h6;
  parameter mubi4_t MuBi4False = 4'h9;

endpackage

// File: rtl/rom_ctrl_pkg.sv
// Shared types for the ROM check sequencer.
//
// Every pair of legal codes differs in at least three bits. The all-ones
// code is the terminal Invalid state.
package rom_ctrl_pkg;

  typedef enum logic [5:0] {
    ChkIdle    = 6'b000111,
    ChkRead    = 6'b011001,
    ChkWait    = 6'b101010,
    ChkDone    = 6'b110100,
    ChkInvalid = 6'b111111
  } chk_state_e;

  // Returns 1 only for the four states a healthy sweep can be in.
  function automatic logic chk_state_legal(chk_state_e s);
    case (s)
      ChkIdle, ChkRead, ChkWait, ChkDone: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/prim_flop.sv
// Generic resettable register with a configurable reset value.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   d_i    - next value
//   q_o    - registered value, ResetValue while in reset
module prim_flop #(
  parameter int                 Width      = 1,
  parameter logic [Width-1:0]   ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_o <= ResetValue;
    else         q_o <= d_i;
  end

endmodule

// File: rtl/rom_ctrl_chk_buf.sv
// One-entry output buffer between the ROM read path and the hash consumer.
// It also holds a flag that marks words from the trailing digest region.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   wr_i          - capture wdata_i (only issued while the buffer is empty)
//   wdata_i       - word returned by the ROM
//   waddr_i       - address of that word, used to derive the top flag
//   rdy_i         - consumer accepts the buffered word
//   data_o        - buffered word, held stable until accepted
//   vld_o         - buffer holds a word
//   top_o         - buffered word lies at or above TopStart
module rom_ctrl_chk_buf #(
  parameter int              DW       = 39,
  parameter int              CntW     = 5,
  parameter logic [CntW-1:0] TopStart = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [CntW-1:0] waddr_i,
  input  logic            rdy_i,
  output logic [DW-1:0]   data_o,
  output logic            vld_o,
  output logic            top_o
);

  logic          vld_q, vld_d;
  logic          top_q, top_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    top_d  = top_q;
    data_d = data_q;
    if (wr_i) begin
      vld_d  = 1'b1;
      data_d = wdata_i;
      top_d  = (waddr_i >= TopStart);
    end else if (vld_q && rdy_i) begin
      // The top flag describes the buffered word, so it goes with it. The
      // data itself is left in place.
      vld_d = 1'b0;
      top_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      top_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      top_q  <= top_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;
  assign vld_o  = vld_q;
  assign top_o  = top_q;

endmodule

// File: rtl/rom_ctrl_chk_seq.sv
// ROM check sequencer. After start_i it reads every ROM word in address
// order through the checker port. Each word goes through a one-entry
// buffer to the hash/compare consumer. Once the sweep is complete, the ROM
// is handed to the bus.
// Ports:
//   clk_i, rst_ni    - clock, asynchronous active-low reset
//   start_i          - begin the sweep (only honoured in Idle)
//   chk_req_o        - single-cycle read request
//   chk_addr_o       - word address of the request
//   chk_rdata_i      - read data, valid together with rom_rvalid_i
//   rom_rvalid_i     - read response, exactly one cycle after the request
//   data_o           - buffered word to the consumer
//   data_vld_o       - data_o valid
//   data_rdy_i       - consumer accepts data_o
//   top_o            - data_o is one of the last NumTopWords words
//   sel_bus_o        - mubi4; true hands the ROM to the bus (Done only)
//   alert_o          - sticky fatal consistency alert
module rom_ctrl_chk_seq
  import rom_ctrl_pkg::*;
  import prim_mubi_pkg::*;
#(
  parameter int  RomDepth    = 16,
  parameter int  NumTopWords = 8,
  parameter int  DW          = 39,
  localparam int AW          = $clog2(RomDepth)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  output logic          chk_req_o,
  output logic [AW-1:0] chk_addr_o,
  input  logic [DW-1:0] chk_rdata_i,
  input  logic          rom_rvalid_i,
  output logic [DW-1:0] data_o,
  output logic          data_vld_o,
  input  logic          data_rdy_i,
  output logic          top_o,
  output logic [3:0]    sel_bus_o,
  output logic          alert_o
);

  localparam int              CntW      = AW + 1;
  localparam logic [CntW-1:0] DepthC    = CntW'(RomDepth);
  localparam logic [CntW-1:0] TopStartC = CntW'(RomDepth - NumTopWords);

  chk_state_e      state_q, state_d;
  logic [CntW-1:0] addr_q, addr_d;
  logic [CntW-1:0] dn_cnt_q, dn_cnt_d;
  logic            pend_q;
  logic            alert_q, alert_d;
  logic            capture, drain_ok, fault;
  mubi4_t          sel_bus_d;

  // pend_q marks the single Wait cycle in which the response must arrive.
  assign capture  = (state_q == ChkWait) && pend_q && rom_rvalid_i;
  // The next request may go out only if the buffer is empty, or is being
  // emptied in this cycle.
  assign drain_ok = !data_vld_o || data_rdy_i;

  always_comb begin
    state_d   = state_q;
    sel_bus_d = MuBi4False;
    case (state_q)
      ChkIdle:    if (start_i) state_d = ChkRead;
      ChkRead:    state_d = ChkWait;
      // The cycle that captures a word stays in Wait. The buffer is full
      // in the following cycle, so the decision is taken there.
      ChkWait:    if (!pend_q && drain_ok) state_d = (addr_q == DepthC) ? ChkDone : ChkRead;
      ChkDone:    state_d = ChkDone;
      ChkInvalid: state_d = ChkInvalid;
      default:    state_d = ChkInvalid;
    endcase
    if (state_d == ChkDone) sel_bus_d = MuBi4True;
  end

  // The up-counter saturates at RomDepth and the down-counter at zero.
  // Their sum must equal RomDepth at all times.
  assign addr_d   = (capture && addr_q != DepthC) ? addr_q + CntW'(1) : addr_q;
  assign dn_cnt_d = (capture && dn_cnt_q != '0) ? dn_cnt_q - CntW'(1) : dn_cnt_q;

  assign fault = (rom_rvalid_i && state_q != ChkWait)
              || (state_q == ChkWait && pend_q && !rom_rvalid_i)
              || !chk_state_legal(state_q)
              || (({1'b0, addr_q} + {1'b0, dn_cnt_q}) != {1'b0, DepthC});
  assign alert_d = alert_q | fault;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ChkIdle;
      addr_q   <= '0;
      dn_cnt_q <= DepthC;
      pend_q   <= 1'b0;
      alert_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dn_cnt_q <= dn_cnt_d;
      pend_q   <= (state_q == ChkRead);
      alert_q  <= alert_d;
    end
  end

  rom_ctrl_chk_buf #(
    .DW      (DW),
    .CntW    (CntW),
    .TopStart(TopStartC)
  ) u_buf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .wr_i   (capture),
    .wdata_i(chk_rdata_i),
    .waddr_i(addr_q),
    .rdy_i  (data_rdy_i),
    .data_o (data_o),
    .vld_o  (data_vld_o),
    .top_o  (top_o)
  );

  prim_flop #(
    .Width     (4),
    .ResetValue(MuBi4False)
  ) u_sel_flop (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (sel_bus_d),
    .q_o   (sel_bus_o)
  );

  assign chk_req_o  = (state_q == ChkRead);
  assign chk_addr_o = addr_q[AW-1:0];
  assign alert_o    = alert_q;

endmodule

// File: tb/tb_rom_ctrl_chk_seq.sv
module tb_rom_ctrl_chk_seq;

  localparam int DEPTH = 16;
  localparam int NTOP  = 8;
  localparam int DW    = 39;
  localparam int AW    = 4;
  localparam logic [3:0] MUBI_T = 4'h6;
  localparam logic [3:0] MUBI_F = 4'h9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          rvalid = 1'b0;
  logic          rdy = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          req, vld, top, alert;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [3:0]    sel;

  always #5 clk = ~clk;

  rom_ctrl_chk_seq #(
    .RomDepth   (DEPTH),
    .NumTopWords(NTOP),
    .DW         (DW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .chk_req_o   (req),
    .chk_addr_o  (addr),
    .chk_rdata_i (rdata),
    .rom_rvalid_i(rvalid),
    .data_o      (data),
    .data_vld_o  (vld),
    .data_rdy_i  (rdy),
    .top_o       (top),
    .sel_bus_o   (sel),
    .alert_o     (alert)
  );

  int n_vec = 0;
  int n_err = 0;

  // ROM contents and bench controls
  logic [DW-1:0] rom [DEPTH];
  int  rdy_mode  = 0;   // 0: always ready, 1: random, 2: stall 10 cycles on first word
  int  drop_at   = -1;  // request index whose response is withheld
  int  pulse_req = -1;  // pulse start in the cycle after this request
  bit  start_nx  = 1'b0;
  bit  stray_nx  = 1'b0;
  bit  addr_chk  = 1'b1;

  // Reference model: the k-th request must carry address k, and the k-th
  // accepted word must be rom[k], flagged top when k >= DEPTH-NTOP.
  bit            req_seen = 1'b0;
  logic [AW-1:0] req_addr_seen = '0;
  int            req_idx_seen = 0;
  int            exp_req = 0;
  int            exp_word = 0;
  int            held = 0;
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_top = 1'b0;

  typedef struct {
    bit         do_start;
    int         drop_req;
    int         stray_cyc;
    int         ncyc;
    bit         exp_alert;
    logic [3:0] exp_sel;
    int         exp_words;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fill_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = DW'({$urandom, $urandom});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   64'(req),   64'd0);
    chk({tag, "_addr"},  64'(addr),  64'd0);
    chk({tag, "_vld"},   64'(vld),   64'd0);
    chk({tag, "_data"},  64'(data),  64'd0);
    chk({tag, "_top"},   64'(top),   64'd0);
    chk({tag, "_sel"},   64'(sel),   64'(MUBI_F));
    chk({tag, "_alert"}, 64'(alert), 64'd0);
  endtask

  // Advance one clock: drive inputs just after the rising edge, then
  // sample and score outputs on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    start = start_nx || (pulse_req >= 0 && req_seen && req_idx_seen == pulse_req);
    case (rdy_mode)
      0:       rdy = 1'b1;
      1:       rdy = ($urandom_range(0, 3) != 0);
      default: rdy = (exp_word > 0) || (held >= 10);
    endcase
    rvalid = stray_nx || (req_seen && req_idx_seen != drop_at);
    if (req_seen && req_idx_seen == drop_at) addr_chk = 1'b0;
    rdata = req_seen ? rom[req_addr_seen] : DW'($urandom);
    stray_nx = 1'b0;
    @(negedge clk);
    if (prev_hold) begin
      chk("hold_vld",  64'(vld),  64'd1);
      chk("hold_data", 64'(data), 64'(prev_data));
      chk("hold_top",  64'(top),  64'(prev_top));
    end
    prev_hold = vld && !rdy;
    prev_data = data;
    prev_top  = top;
    if (rdy_mode == 2 && vld && !rdy) begin
      held++;
      chk("stall_noreq", 64'(req), 64'd0);
    end
    if (vld && rdy) begin
      if (exp_word < DEPTH) begin
        chk("word_data", 64'(data), 64'(rom[exp_word]));
        chk("word_top",  64'(top),  64'(exp_word >= DEPTH - NTOP));
        chk("sel_busy",  64'(sel),  64'(MUBI_F));
      end else begin
        chk("word_count", 64'(exp_word), 64'(DEPTH - 1));
      end
      exp_word++;
    end
    req_seen = req;
    if (req) begin
      if (addr_chk) chk("req_addr", 64'(addr), 64'(exp_req));
      if (vld && !rdy) chk("req_while_full", 64'(req), 64'd0);
      req_addr_seen = addr;
      req_idx_seen  = exp_req;
      exp_req++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; rvalid = 1'b0; rdy = 1'b0; rdata = '0;
    start_nx = 1'b0; stray_nx = 1'b0; drop_at = -1; pulse_req = -1;
    rdy_mode = 0; addr_chk = 1'b1;
    req_seen = 1'b0; exp_req = 0; exp_word = 0; held = 0; prev_hold = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start_nx = 1'b1;
    tick();
    start_nx = 1'b0;
  endtask

  task automatic run_done(input int budget);
    int cyc = 0;
    while (!(exp_word >= DEPTH && sel === MUBI_T) && cyc < budget) begin
      tick();
      cyc++;
    end
    chk("done_words", 64'(exp_word), 64'(DEPTH));
    chk("done_reqs",  64'(exp_req),  64'(DEPTH));
    chk("done_sel",   64'(sel),      64'(MUBI_T));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    //            start drop stray ncyc alert sel     words
    vt[0] = '{1'b0, -1, -1, 10, 1'b0, MUBI_F,  0};   // idle, quiet
    vt[1] = '{1'b0, -1,  2,  5, 1'b1, MUBI_F,  0};   // rvalid in Idle
    vt[2] = '{1'b1, -1, -1, 60, 1'b0, MUBI_T, 16};   // full sweep
    vt[3] = '{1'b1, -1, 55, 60, 1'b1, MUBI_T, 16};   // rvalid in Done
    vt[4] = '{1'b1,  0, -1,  8, 1'b1, MUBI_F, -1};   // first response missing
    vt[5] = '{1'b1, 10, -1, 40, 1'b1, MUBI_F, -1};   // response 10 missing
    vt[6] = '{1'b1, -1,  1,  6, 1'b1, MUBI_F, -1};   // rvalid during Read

    for (int v = 0; v < 7; v++) begin
      do_reset();
      fill_rom();
      drop_at = vt[v].drop_req;
      if (vt[v].do_start) start_nx = 1'b1;
      for (int c = 0; c < vt[v].ncyc; c++) begin
        if (c == vt[v].stray_cyc) stray_nx = 1'b1;
        tick();
        start_nx = 1'b0;
      end
      chk($sformatf("vec%0d_alert", v), 64'(alert), 64'(vt[v].exp_alert));
      chk($sformatf("vec%0d_sel", v),   64'(sel),   64'(vt[v].exp_sel));
      if (vt[v].exp_words >= 0)
        chk($sformatf("vec%0d_words", v), 64'(exp_word), 64'(vt[v].exp_words));
    end

    // Rvalid in the cycle right after reset release.
    do_reset();
    rvalid = 1'b1;
    @(posedge clk);
    #1 rvalid = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid_alert", 64'(alert), 64'd1);
    repeat (3) tick();
    chk("post_rst_rvalid_sticky", 64'(alert), 64'd1);

    // Consumer stalls 10 cycles on the first word.
    do_reset();
    fill_rom();
    rdy_mode = 2;
    pulse_start();
    run_done(300);
    chk("stall_len",   64'(held),  64'd10);
    chk("stall_alert", 64'(alert), 64'd0);

    // Start pulses in Wait and in Done are ignored.
    do_reset();
    fill_rom();
    pulse_req = 3;
    pulse_start();
    run_done(300);
    chk("start_wait_alert", 64'(alert), 64'd0);
    pulse_req = -1;
    pulse_start();
    repeat (3) tick();
    chk("done_sticky_sel", 64'(sel),     64'(MUBI_T));
    chk("done_no_req",     64'(exp_req), 64'(DEPTH));

    // Redundant down-counter corrupted at word 5.
    do_reset();
    fill_rom();
    pulse_start();
    cyc = 0;
    while (exp_word < 5 && cyc < 100) begin tick(); cyc++; end
    chk("force_reach", 64'(exp_word), 64'd5);
    chk("pre_force_alert", 64'(alert), 64'd0);
    force dut.dn_cnt_q = 5'd0;
    tick();
    release dut.dn_cnt_q;
    chk("force_alert", 64'(alert), 64'd1);
    repeat (4) tick();
    chk("force_sticky", 64'(alert), 64'd1);

    // Reset at word 7, then a fresh sweep from address 0.
    do_reset();
    fill_rom();
    pulse_start();
    cyc = 0;
    while (exp_word < 7 && cyc < 100) begin tick(); cyc++; end
    chk("rst_reach", 64'(exp_word), 64'd7);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    do_reset();
    pulse_start();
    run_done(300);
    chk("restart_alert", 64'(alert), 64'd0);

    // Randomised back-pressure sweeps.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      fill_rom();
      rdy_mode = 1;
      pulse_start();
      run_done(500);
      chk($sformatf("rand%0d_alert", r), 64'(alert), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
